// File: rtl/pll_lock_supervisor.sv
// Supervises an ECP5 EHXPLLL from the free-running board clock: pulses PLL RST,
// waits for a stable LOCK, releases downstream reset, and retries or faults on timeout.
//
// state     | meaning
// PLL_RESET | pll_rst held high for RST_PULSE cycles
// WAIT_LOCK | pll_rst low, waiting for synchronised lock or timeout
// STABILISE | lock seen, must stay high for STABLE_CYCLES cycles
// RUN       | downstream released, ready high
// FAULT     | retries exhausted, held until reset
module pll_lock_supervisor #(
  parameter int SYNC_STAGES   = 2,
  parameter int RST_PULSE     = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       locked_in,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic       fault,
  output logic [7:0] lock_lost_count,
  output logic [7:0] retry_count
);

  localparam int MAX_AB    = (RST_PULSE > LOCK_TIMEOUT) ? RST_PULSE : LOCK_TIMEOUT;
  localparam int TIMER_MAX = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int TW        = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

  localparam logic [TW-1:0] RST_LAST     = TW'(RST_PULSE - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);
  localparam logic [7:0]    RETRY_LIMIT  = 8'(MAX_RETRIES);

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILISE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } stateT;

  stateT                  state, stateNext;
  logic [TW-1:0]          timer, timerNext;
  logic [7:0]             retryNext, lostNext;
  logic [SYNC_STAGES-1:0] syncQ;
  logic                   lockedS;

  assign lockedS = syncQ[SYNC_STAGES-1];

  always_ff @(posedge clock) begin
    if (reset) syncQ <= '0;
    else       syncQ <= {syncQ[SYNC_STAGES-2:0], locked_in};
  end

  always_comb begin
    stateNext = state;
    timerNext = timer;
    retryNext = retry_count;
    lostNext  = lock_lost_count;
    case (state)
      PLL_RESET: begin
        if (timer == RST_LAST) begin
          stateNext = WAIT_LOCK;
          timerNext = '0;
        end else begin
          timerNext = timer + TW'(1);
        end
      end
      WAIT_LOCK: begin
        // Lock takes priority over a timeout landing on the same cycle.
        if (lockedS) begin
          stateNext = STABILISE;
          timerNext = '0;
        end else if (timer == TIMEOUT_LAST) begin
          timerNext = '0;
          retryNext = (retry_count == 8'hFF) ? retry_count : retry_count + 8'd1;
          if ((MAX_RETRIES != 0) && (retryNext == RETRY_LIMIT)) stateNext = FAULT;
          else                                                  stateNext = PLL_RESET;
        end else begin
          timerNext = timer + TW'(1);
        end
      end
      STABILISE: begin
        if (!lockedS) begin
          stateNext = WAIT_LOCK;
          timerNext = '0;
        end else if (timer == STABLE_LAST) begin
          stateNext = RUN;
          timerNext = '0;
          retryNext = 8'd0;
        end else begin
          timerNext = timer + TW'(1);
        end
      end
      RUN: begin
        if (!lockedS) begin
          stateNext = WAIT_LOCK;
          timerNext = '0;
          lostNext  = (lock_lost_count == 8'hFF) ? lock_lost_count : lock_lost_count + 8'd1;
        end
      end
      FAULT: begin
        stateNext = FAULT;
      end
      default: begin
        stateNext = PLL_RESET;
        timerNext = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= PLL_RESET;
      timer           <= '0;
      retry_count     <= 8'd0;
      lock_lost_count <= 8'd0;
      pll_rst         <= 1'b1;
      sys_reset       <= 1'b1;
      ready           <= 1'b0;
      fault           <= 1'b0;
    end else begin
      state           <= stateNext;
      timer           <= timerNext;
      retry_count     <= retryNext;
      lock_lost_count <= lostNext;
      pll_rst         <= (stateNext == PLL_RESET);
      sys_reset       <= (stateNext != RUN);
      ready           <= (stateNext == RUN);
      fault           <= (stateNext == FAULT);
    end
  end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Consumer side of the ECP5 EHXPLLL clock generator. It drives the PLL RST input and watches the asynchronous LOCK output.
- Runs on the free-running 25 MHz board clock, not on any PLL output.
- Holds the design in reset until lock has been stable for a programmable time. Reasserts reset on lock loss.
- Re-pulses PLL RST when lock is not regained within a timeout. Flags a fault after repeated failures.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the locked_in synchroniser (minimum 2).
- RST_PULSE, 16, cycles pll_rst is held high per PLL reset attempt (minimum 1).
- LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK before a retry.
- STABLE_CYCLES, 1024, consecutive locked cycles required before release (minimum 1).
- MAX_RETRIES, 3, timeouts tolerated before FAULT (0 = retry forever).

Ports:
- clock, in, 1, 25 MHz free-running reference clock.
- reset, in, 1, synchronous, active-high.
- locked_in, in, 1, PLL LOCK, asynchronous to clock.
- pll_rst, out, 1, to EHXPLLL RST (requires PLLRST_ENA enabled on the PLL).
- sys_reset, out, 1, active-high reset for downstream logic.
- ready, out, 1, high while in RUN.
- fault, out, 1, high in FAULT.
- lock_lost_count, out, 8, saturating count of lock losses seen in RUN.
- retry_count, out, 8, timeouts since the last entry to RUN.

Behaviour:
- Reset is synchronous and active-high. On reset:
  - state=PLL_RESET, all counters 0, synchroniser flops 0.
  - pll_rst=1, sys_reset=1, ready=0, fault=0, lock_lost_count=0, retry_count=0.
- locked_s is locked_in after SYNC_STAGES flops. The FSM uses only locked_s.
- All outputs are flops updated on the same edge as the state register, so they are glitch-free.
- PLL_RESET:
  - pll_rst=1, sys_reset=1.
  - timer counts 0..RST_PULSE-1, then WAIT_LOCK with timer cleared.
  - pll_rst is high for exactly RST_PULSE cycles.
- WAIT_LOCK:
  - pll_rst=0, sys_reset=1.
  - locked_s=1 -> STABILISE, timer cleared.
  - Else at timer==LOCK_TIMEOUT-1: retry_count+1 (saturating at 255).
    - If MAX_RETRIES!=0 and the new retry_count==MAX_RETRIES -> FAULT.
    - Otherwise -> PLL_RESET.
  - If locked_s rises on the timeout cycle, lock wins: go to STABILISE, no retry.
- STABILISE:
  - sys_reset=1.
  - locked_s=0 on any cycle -> WAIT_LOCK, timer cleared, retry_count unchanged.
  - timer==STABLE_CYCLES-1 with locked_s=1 -> RUN.
  - Occupies exactly STABLE_CYCLES cycles.
- RUN:
  - sys_reset=0, ready=1, retry_count cleared on entry.
  - locked_s=0 -> WAIT_LOCK, lock_lost_count+1 (saturating at 255), timer cleared.
  - sys_reset=1 and ready=0 are registered on that same edge: one cycle after locked_s falls.
- FAULT:
  - pll_rst=0, sys_reset=1, ready=0, fault=1.
  - locked_in is ignored. Exit only via reset.
- Latency: locked_s first seen high in WAIT_LOCK -> sys_reset low after 1+STABLE_CYCLES cycles. Add SYNC_STAGES cycles from locked_in.
- reset asserted in any state (including RUN or mid-pulse):
  - Next edge restores reset values: sys_reset=1 and pll_rst=1 immediately.
  - lock_lost_count also clears.
- Timer width is clog2 of max(RST_PULSE, LOCK_TIMEOUT, STABLE_CYCLES). It never wraps; every terminal compare leaves the state.

Test Plan:
All scenarios use SYNC_STAGES=2, RST_PULSE=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2.
- Power-up, locked_in rises 10 cycles after reset release:
  - pll_rst is high cycles 0-3 then 0.
  - sys_reset falls exactly 2+1+8 cycles after the locked_in edge.
  - ready=1 and fault=0 from then on.
- Glitch in STABILISE: locked_in drops for 3 cycles after 5 stable cycles.
  - No release; the state returns to WAIT_LOCK.
  - After locked_in rises again, release takes the full 8+1+2 cycles.
  - retry_count stays 0.
- Lock loss in RUN: drop locked_in for 20 cycles.
  - sys_reset=1 and ready=0 on the 3rd cycle after the fall.
  - lock_lost_count=1.
  - Relock releases after 11 cycles; no pll_rst pulse.
- Timeout retry: locked_in held low.
  - After 4+32 cycles pll_rst pulses high for 4 cycles and retry_count=1.
  - After the second timeout: fault=1, pll_rst=0, sys_reset=1.
  - A later locked_in=1 causes no change.
- Reset mid-RUN: assert reset for 1 cycle while ready=1.
  - Next edge gives sys_reset=1, ready=0, pll_rst=1, lock_lost_count=0.
  - A full re-sequence follows.
- Saturation: 300 lock-loss/relock cycles leave lock_lost_count at 255.
